// File: rtl/imem_loadable.sv
// Two-region (kernel/user) instruction memory for the pipelined MIPS core.
// Fetches have 1-cycle latency; contents are filled at run time from a byte stream.
module imem_loadable #(
    parameter int          KERN_AW      = 6,
    parameter int          USER_AW      = 8,
    parameter int          REGION_BIT   = 22,
    parameter logic [31:0] DEFAULT_INSN = 32'h0800_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_req,
    input  logic [31:0]        fetch_addr,
    output logic [31:0]        fetch_data,
    output logic               fetch_valid,
    output logic               fetch_fault,
    input  logic               load_start,
    input  logic               load_region,
    input  logic [7:0]         load_byte,
    input  logic               load_byte_valid,
    input  logic               load_end,
    output logic               loading,
    output logic [USER_AW:0]   load_words,
    output logic               load_overflow,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FLUSH} state_t;

    localparam int KDEPTH = 1 << KERN_AW;
    localparam int UDEPTH = 1 << USER_AW;
    localparam logic [USER_AW:0] KDEPTH_W = (USER_AW+1)'(KDEPTH);
    localparam logic [USER_AW:0] UDEPTH_W = (USER_AW+1)'(UDEPTH);

    logic [31:0] kern_mem [KDEPTH];
    logic [31:0] user_mem [UDEPTH];
    logic [KDEPTH-1:0] kern_wr;
    logic [UDEPTH-1:0] user_wr;

    state_t            state;
    logic              lregion;
    logic [USER_AW:0]  ptr;
    logic [1:0]        bcnt;
    logic [31:0]       byte_buf;
    logic              wr_pend;
    logic [31:0]       wr_word;

    // Fetch decode
    logic               f_user, f_mis, f_oor, f_bad, f_wbit;
    logic [KERN_AW-1:0] k_idx;
    logic [USER_AW-1:0] u_idx;
    logic [31:0]        rd_word;
    logic               unused_hi;

    assign f_user  = fetch_addr[REGION_BIT];
    assign k_idx   = fetch_addr[2 +: KERN_AW];
    assign u_idx   = fetch_addr[2 +: USER_AW];
    assign f_mis   = |fetch_addr[1:0];
    assign f_oor   = f_user ? (|fetch_addr[REGION_BIT-1:2+USER_AW])
                            : (|fetch_addr[REGION_BIT-1:2+KERN_AW]);
    assign f_bad   = f_mis | f_oor;
    assign f_wbit  = f_user ? user_wr[u_idx] : kern_wr[k_idx];
    assign rd_word = f_user ? user_mem[u_idx] : kern_mem[k_idx];
    // Address bits above the region bit mirror the map.
    assign unused_hi = ^fetch_addr[31:REGION_BIT+1];

    // Write port: a completed word lands the cycle after its 4th byte; FLUSH writes a partial word.
    logic              do_wr;
    logic [31:0]       wr_data;
    logic              full;
    logic [USER_AW:0]  depth;

    assign do_wr   = wr_pend || (state == ST_FLUSH && bcnt != 2'd0);
    assign wr_data = wr_pend ? wr_word : byte_buf;
    assign depth   = lregion ? UDEPTH_W : KDEPTH_W;
    assign full    = (ptr + {{USER_AW{1'b0}}, wr_pend}) == depth;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            if (lregion) user_mem[ptr[USER_AW-1:0]] <= wr_data;
            else         kern_mem[ptr[KERN_AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            loading       <= 1'b0;
            load_words    <= '0;
            load_overflow <= 1'b0;
            lregion       <= 1'b0;
            ptr           <= '0;
            bcnt          <= 2'd0;
            byte_buf      <= '0;
            wr_pend       <= 1'b0;
            wr_word       <= '0;
            kern_wr       <= '0;
            user_wr       <= '0;
        end else begin
            wr_pend <= 1'b0;
            if (do_wr) begin
                if (lregion) user_wr[ptr[USER_AW-1:0]] <= 1'b1;
                else         kern_wr[ptr[KERN_AW-1:0]] <= 1'b1;
                ptr        <= ptr + 1'b1;
                load_words <= load_words + 1'b1;
            end
            case (state)
                ST_IDLE, ST_LOAD: begin
                    if (load_start) begin
                        // Open or restart: written words survive, counters and partial word do not.
                        state         <= ST_LOAD;
                        loading       <= 1'b1;
                        lregion       <= load_region;
                        ptr           <= '0;
                        bcnt          <= 2'd0;
                        byte_buf      <= '0;
                        load_words    <= '0;
                        load_overflow <= 1'b0;
                    end else if (state == ST_LOAD) begin
                        if (load_byte_valid) begin
                            if (full) begin
                                load_overflow <= 1'b1;
                            end else if (bcnt == 2'd3) begin
                                wr_word  <= {load_byte, byte_buf[23:0]};
                                wr_pend  <= 1'b1;
                                bcnt     <= 2'd0;
                                byte_buf <= '0;
                            end else begin
                                byte_buf[{bcnt, 3'b000} +: 8] <= load_byte;
                                bcnt <= bcnt + 2'd1;
                            end
                        end
                        if (load_end) state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    state    <= ST_IDLE;
                    loading  <= 1'b0;
                    bcnt     <= 2'd0;
                    byte_buf <= '0;
                end
                default: begin
                    state   <= ST_IDLE;
                    loading <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_valid <= 1'b0;
            fetch_fault <= 1'b0;
            fetch_data  <= DEFAULT_INSN;
        end else if (fetch_req && !loading) begin
            fetch_valid <= 1'b1;
            fetch_fault <= f_bad;
            fetch_data  <= (!f_bad && f_wbit) ? rd_word : DEFAULT_INSN;
        end else begin
            fetch_valid <= 1'b0;
            fetch_fault <= 1'b0;
            fetch_data  <= DEFAULT_INSN;
        end
    end

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable: region loads, decode faults, overflow, stalls and reset.
module tb_imem_loadable;

    localparam logic [31:0] DEF = 32'h0800_0000;

    logic        clk;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_data;
    logic        fetch_valid;
    logic        fetch_fault;
    logic        load_start;
    logic        load_region;
    logic [7:0]  load_byte;
    logic        load_byte_valid;
    logic        load_end;
    logic        loading;
    logic [8:0]  load_words;
    logic        load_overflow;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    logic [7:0] byte_q[$];

    imem_loadable dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_data(fetch_data), .fetch_valid(fetch_valid), .fetch_fault(fetch_fault),
        .load_start(load_start), .load_region(load_region),
        .load_byte(load_byte), .load_byte_valid(load_byte_valid), .load_end(load_end),
        .loading(loading), .load_words(load_words), .load_overflow(load_overflow),
        .dbg_state(dbg_state)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Driver tasks: inputs change 1ns after a rising edge, outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        load_byte = b;
        load_byte_valid = 1'b1;
        tick();
        load_byte_valid = 1'b0;
    endtask

    task automatic run_session(input logic region);
        load_start = 1'b1;
        load_region = region;
        tick();
        load_start = 1'b0;
        foreach (byte_q[i]) send_byte(byte_q[i]);
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        tick();
    endtask

    task automatic do_fetch(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_data, input logic exp_fault);
        fetch_req = 1'b1;
        fetch_addr = addr;
        tick();
        fetch_req = 1'b0;
        check({tag, "_valid"}, {31'b0, fetch_valid}, 32'd1);
        check({tag, "_data"}, fetch_data, exp_data);
        check({tag, "_fault"}, {31'b0, fetch_fault}, {31'b0, exp_fault});
    endtask

    initial begin
        int bad_cycles;
        reset = 1'b0;
        fetch_req = 1'b0;
        fetch_addr = '0;
        load_start = 1'b0;
        load_region = 1'b0;
        load_byte = '0;
        load_byte_valid = 1'b0;
        load_end = 1'b0;
        #22;
        check("rst_data", fetch_data, DEF);
        check("rst_valid", {31'b0, fetch_valid}, 32'd0);
        check("rst_fault", {31'b0, fetch_fault}, 32'd0);
        check("rst_loading", {31'b0, loading}, 32'd0);
        check("rst_words", {23'b0, load_words}, 32'd0);
        check("rst_ovf", {31'b0, load_overflow}, 32'd0);
        reset = 1'b1;
        tick();

        do_fetch("boot0", 32'h0000_0000, DEF, 1'b0);
        tick();
        check("idle_novalid", {31'b0, fetch_valid}, 32'd0);

        // load_end in IDLE has no effect
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        tick();
        check("stray_end", {31'b0, loading}, 32'd0);

        byte_q = '{8'h20, 8'hf8, 8'h00, 8'h00, 8'h20, 8'hf8, 8'h1f, 8'h3c};
        run_session(1'b0);
        check("k_words", {23'b0, load_words}, 32'd2);
        check("k_ovf", {31'b0, load_overflow}, 32'd0);
        do_fetch("k0", 32'h0000_0000, 32'h0000_f820, 1'b0);
        do_fetch("k1", 32'h0000_0004, 32'h3c1f_f820, 1'b0);
        do_fetch("k1_mirror", 32'h8000_0004, 32'h3c1f_f820, 1'b0);
        do_fetch("k2_unwr", 32'h0000_0008, DEF, 1'b0);

        byte_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'haa};
        run_session(1'b1);
        check("u_words", {23'b0, load_words}, 32'd2);
        do_fetch("u0", 32'h0040_0000, 32'h0403_0201, 1'b0);
        do_fetch("u1_pad", 32'h0040_0004, 32'h0000_00aa, 1'b0);
        do_fetch("u2_unwr", 32'h0040_0008, DEF, 1'b0);
        do_fetch("k0_keep", 32'h0000_0000, 32'h0000_f820, 1'b0);

        do_fetch("misalign", 32'h0000_0002, DEF, 1'b1);
        do_fetch("k_oor", 32'h0000_0100, DEF, 1'b1);
        do_fetch("u_top_ok", 32'h0040_03fc, DEF, 1'b0);
        do_fetch("u_oor", 32'h0040_0400, DEF, 1'b1);

        // Held fetch across a session with a restart; partial bytes 99,88 must vanish
        load_start = 1'b1;
        load_region = 1'b0;
        tick();
        load_start = 1'b0;
        check("sess_loading", {31'b0, loading}, 32'd1);
        fetch_req = 1'b1;
        fetch_addr = 32'h0000_0004;
        bad_cycles = 0;
        send_byte(8'h99);
        if (fetch_valid !== 1'b0) bad_cycles++;
        send_byte(8'h88);
        if (fetch_valid !== 1'b0) bad_cycles++;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        if (fetch_valid !== 1'b0) bad_cycles++;
        check("restart_words", {23'b0, load_words}, 32'd0);
        byte_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        foreach (byte_q[i]) begin
            send_byte(byte_q[i]);
            if (fetch_valid !== 1'b0 || loading !== 1'b1) bad_cycles++;
        end
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        check("flush_loading", {31'b0, loading}, 32'd1);
        if (fetch_valid !== 1'b0) bad_cycles++;
        tick();
        check("post_flush_loading", {31'b0, loading}, 32'd0);
        check("post_flush_valid", {31'b0, fetch_valid}, 32'd0);
        check("stall_cycles", bad_cycles, 32'd0);
        tick();
        fetch_req = 1'b0;
        check("held_valid", {31'b0, fetch_valid}, 32'd1);
        check("held_data", fetch_data, 32'h3c1f_f820);
        check("restart_wcount", {23'b0, load_words}, 32'd1);
        do_fetch("restart_w0", 32'h0000_0000, 32'h4433_2211, 1'b0);

        // Fill kernel: 256 bytes plus 4 overflow bytes
        byte_q.delete();
        for (int k = 0; k < 256; k++) byte_q.push_back(8'(k));
        for (int k = 0; k < 4; k++) byte_q.push_back(8'hee);
        run_session(1'b0);
        check("fill_words", {23'b0, load_words}, 32'd64);
        check("fill_ovf", {31'b0, load_overflow}, 32'd1);
        do_fetch("fill_w0", 32'h0000_0000, 32'h0302_0100, 1'b0);
        do_fetch("fill_w63", 32'h0000_00fc, 32'hfffe_fdfc, 1'b0);
        do_fetch("fill_u_keep", 32'h0040_0004, 32'h0000_00aa, 1'b0);

        // Reset mid-session while overflowed
        load_start = 1'b1;
        load_region = 1'b0;
        tick();
        load_start = 1'b0;
        foreach (byte_q[i]) send_byte(byte_q[i]);
        check("mid_ovf", {31'b0, load_overflow}, 32'd1);
        check("mid_words", {23'b0, load_words}, 32'd64);
        reset = 1'b0;
        #1;
        check("mid_rst_loading", {31'b0, loading}, 32'd0);
        check("mid_rst_words", {23'b0, load_words}, 32'd0);
        check("mid_rst_ovf", {31'b0, load_overflow}, 32'd0);
        check("mid_rst_data", fetch_data, DEF);
        check("mid_rst_state", {30'b0, dbg_state}, 32'd0);
        #2;
        reset = 1'b1;
        tick();
        do_fetch("rst_k0", 32'h0000_0000, DEF, 1'b0);
        do_fetch("rst_u0", 32'h0040_0000, DEF, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
